// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing types and constants.
// FSM state encoding, 8N1 frame constants, bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // A programmed period of zero runs at one clock per bit.
  function automatic logic [15:0] fix_period(
    input logic [15:0] p
  );
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage

// File: rtl/uart_tx_prog_if.sv
// uart_tx_prog_if: host-side bundle of the UART transmitter.
// master = host (period, write strobe, byte); slave = transmitter.
interface uart_tx_prog_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   CLKS_PER_BIT;
  logic          i_Tx_DV;
  logic [7:0]    i_Tx_Byte;
  logic          o_Tx_Ready;
  logic          o_Tx_Serial;
  logic          o_Tx_Active;
  logic          o_Tx_Done;
  logic [CW-1:0] o_Fifo_Count;

  modport master (
    output CLKS_PER_BIT,
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Tx_Serial,
    input  o_Tx_Active,
    input  o_Tx_Done,
    input  o_Fifo_Count
  );

  modport slave (
    input  CLKS_PER_BIT,
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Tx_Serial,
    output o_Tx_Active,
    output o_Tx_Done,
    output o_Fifo_Count
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, power-of-two DEPTH, sync reset.
// wr_en/wr_data push, rd_en pops, rd_data shows head; full/empty/count.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_Clock,
  input  logic                   rst_i,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)
        count <= count + 1'b1;
      else if (!do_wr && do_rd)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_prog.sv
// uart_tx_prog: 8N1 UART transmitter, run-time bit period, input FIFO.
// Ports: i_Clock, rst_i (sync, active-high), bus (slave modport).
module uart_tx_prog #(
  parameter int FIFO_DEPTH = 4
) (
  input logic           i_Clock,
  input logic           rst_i,
  uart_tx_prog_if.slave bus
);
  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e state;
  logic [15:0] period;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tx_serial;
  logic        tx_active;
  logic        tx_done;

  logic [7:0]    fifo_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          bit_end;
  logic          pop;

  assign bit_end = (clk_cnt == period - 16'd1);

  // Pop either from idle or on the last stop-bit cycle,
  // so queued frames follow each other with no gap.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) ||
                (state == ST_STOP && bit_end));

  uart_tx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_Clock(i_Clock),
    .rst_i  (rst_i),
    .wr_en  (bus.i_Tx_DV && !fifo_full),
    .wr_data(bus.i_Tx_Byte),
    .rd_en  (pop),
    .rd_data(fifo_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bus.o_Tx_Ready   = !fifo_full;
  assign bus.o_Fifo_Count = fifo_count;
  assign bus.o_Tx_Serial  = tx_serial;
  assign bus.o_Tx_Active  = tx_active;
  assign bus.o_Tx_Done    = tx_done;

  always_ff @(posedge i_Clock) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      period    <= 16'd1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx_serial <= STOP_LVL;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          tx_serial <= STOP_LVL;
          tx_active <= 1'b0;
          if (pop) begin
            shift     <= fifo_data;
            period    <= fix_period(bus.CLKS_PER_BIT);
            clk_cnt   <= '0;
            bit_idx   <= '0;
            tx_serial <= START_LVL;
            tx_active <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            tx_serial <= shift[0];
            state     <= ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              tx_serial <= STOP_LVL;
              state     <= ST_STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shift[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx_done <= 1'b1;
            if (pop) begin
              shift     <= fifo_data;
              period    <= fix_period(bus.CLKS_PER_BIT);
              bit_idx   <= '0;
              tx_serial <= START_LVL;
              state     <= ST_START;
            end else begin
              tx_active <= 1'b0;
              state     <= ST_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_prog.sv
// tb_uart_tx_prog: scenario tasks against a frame-level line model.
// Samples every negedge into queues; the model derives each bit slot.
module tb_uart_tx_prog;

  localparam int DEPTH = 4;

  logic i_Clock = 1'b0;
  logic rst_i   = 1'b1;

  always #5 i_Clock = ~i_Clock;

  uart_tx_prog_if #(.FIFO_DEPTH(DEPTH)) bus();

  uart_tx_prog #(.FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(i_Clock),
    .rst_i  (rst_i),
    .bus    (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic ser_q[$];
  logic act_q[$];
  logic done_q[$];
  logic rdy_q[$];
  int   cnt_q[$];

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge i_Clock);
    ser_q.push_back(bus.o_Tx_Serial);
    act_q.push_back(bus.o_Tx_Active);
    done_q.push_back(bus.o_Tx_Done);
    rdy_q.push_back(bus.o_Tx_Ready);
    cnt_q.push_back(int'(bus.o_Fifo_Count));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus.i_Tx_DV = 1'b0;
    run(2);
    rst_i = 1'b0;
    run(1);
    ser_q.delete();
    act_q.delete();
    done_q.delete();
    rdy_q.delete();
    cnt_q.delete();
  endtask

  // Sample 0 taken first; byte i is presented after sample i.
  task automatic write_bytes(input logic [7:0] q[$]);
    tick();
    foreach (q[i]) begin
      bus.i_Tx_DV   = 1'b1;
      bus.i_Tx_Byte = q[i];
      tick();
    end
    bus.i_Tx_DV = 1'b0;
  endtask

  // Line level t cycles into a frame: slot 0 start,
  // slots 1..8 data LSB first, slot 9 stop.
  function automatic logic exp_bit(
    input logic [7:0] b, input int p, input int t
  );
    int slot;
    slot = t / p;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  function automatic int frame_errs(
    input int start, input logic [7:0] b, input int p
  );
    int e;
    e = 0;
    for (int t = 0; t < 10*p; t++) begin
      if (start + t >= ser_q.size())
        e++;
      else if (ser_q[start+t] !== exp_bit(b, p, t) ||
               act_q[start+t] !== 1'b1)
        e++;
    end
    return e;
  endfunction

  function automatic int done_count(input int from);
    int n;
    n = 0;
    foreach (done_q[i])
      if (i >= from && done_q[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int active_count(input int from);
    int n;
    n = 0;
    foreach (act_q[i])
      if (i >= from && act_q[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    bus.CLKS_PER_BIT = 16'd4;
    bus.i_Tx_Byte    = 8'h00;
    rst_i = 1'b1;
    bus.i_Tx_DV = 1'b0;
    run(2);
    vectors++;
    if (bus.o_Tx_Serial !== 1'b1) begin
      errors++;
      $display("FAIL reset_serial: got %b want 1", bus.o_Tx_Serial);
    end
    vectors++;
    if (bus.o_Tx_Active !== 1'b0) begin
      errors++;
      $display("FAIL reset_active: got %b want 0", bus.o_Tx_Active);
    end
    vectors++;
    if (bus.o_Tx_Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", bus.o_Tx_Done);
    end
    vectors++;
    if (bus.o_Tx_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.o_Tx_Ready);
    end
    vectors++;
    if (bus.o_Fifo_Count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", bus.o_Fifo_Count);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] q[$];
    int e;
    do_reset();
    bus.CLKS_PER_BIT = 16'd4;
    q = '{8'hA5};
    write_bytes(q);
    run(50);
    vectors++;
    if (cnt_q[1] !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", cnt_q[1]);
    end
    e = frame_errs(2, 8'hA5, 4);
    vectors++;
    if (e !== 0) begin
      errors++;
      $display("FAIL single_frame: bad samples %0d want 0", e);
    end
    vectors++;
    if (done_q[42] !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got %b want 1", done_q[42]);
    end
    vectors++;
    if (act_q[42] !== 1'b0 || ser_q[42] !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: act %b ser %b want 0 1",
               act_q[42], ser_q[42]);
    end
    vectors++;
    if (done_count(0) !== 1) begin
      errors++;
      $display("FAIL single_ndone: got %0d want 1", done_count(0));
    end
    vectors++;
    if (active_count(0) !== 40) begin
      errors++;
      $display("FAIL single_len: got %0d want 40", active_count(0));
    end
  endtask

  task automatic test_burst();
    logic [7:0] q[$];
    int e;
    int peak;
    int rdy_bad;
    do_reset();
    bus.CLKS_PER_BIT = 16'd2;
    q = '{8'h00, 8'hFF, 8'h55, 8'h0F};
    write_bytes(q);
    run(90);
    rdy_bad = 0;
    for (int i = 0; i < 4; i++)
      if (rdy_q[i] !== 1'b1) rdy_bad++;
    vectors++;
    if (rdy_bad !== 0) begin
      errors++;
      $display("FAIL burst_ready: low %0d want 0", rdy_bad);
    end
    peak = 0;
    foreach (cnt_q[i])
      if (cnt_q[i] > peak) peak = cnt_q[i];
    vectors++;
    if (peak < 3 || peak > 4) begin
      errors++;
      $display("FAIL burst_peak: got %0d want 3..4", peak);
    end
    for (int f = 0; f < 4; f++) begin
      e = frame_errs(2 + 20*f, q[f], 2);
      vectors++;
      if (e !== 0) begin
        errors++;
        $display("FAIL burst_frame%0d: bad %0d want 0", f, e);
      end
      vectors++;
      if (done_q[22 + 20*f] !== 1'b1) begin
        errors++;
        $display("FAIL burst_done%0d: got %b want 1",
                 f, done_q[22 + 20*f]);
      end
    end
    vectors++;
    if (done_count(0) !== 4) begin
      errors++;
      $display("FAIL burst_ndone: got %0d want 4", done_count(0));
    end
    vectors++;
    if (act_q[82] !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: active %b want 0", act_q[82]);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    int e;
    do_reset();
    bus.CLKS_PER_BIT = 16'd100;
    for (int i = 0; i < 6; i++)
      q.push_back(8'($urandom));
    write_bytes(q);
    run(5010);
    vectors++;
    if (rdy_q[5] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ready: got %b want 0", rdy_q[5]);
    end
    vectors++;
    if (cnt_q[6] !== 4) begin
      errors++;
      $display("FAIL ovf_count: got %0d want 4", cnt_q[6]);
    end
    for (int f = 0; f < 5; f++) begin
      e = frame_errs(2 + 1000*f, q[f], 100);
      vectors++;
      if (e !== 0) begin
        errors++;
        $display("FAIL ovf_frame%0d: bad %0d want 0", f, e);
      end
    end
    vectors++;
    if (done_count(0) !== 5) begin
      errors++;
      $display("FAIL ovf_ndone: got %0d want 5", done_count(0));
    end
    vectors++;
    if (act_q[5002] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_end: active %b want 0", act_q[5002]);
    end
  endtask

  task automatic test_period_change();
    logic [7:0] q[$];
    int e;
    do_reset();
    bus.CLKS_PER_BIT = 16'd8;
    q = '{8'($urandom), 8'($urandom)};
    write_bytes(q);
    run(18);
    bus.CLKS_PER_BIT = 16'd3;
    run(110);
    e = frame_errs(2, q[0], 8);
    vectors++;
    if (e !== 0) begin
      errors++;
      $display("FAIL per_frame0: bad %0d want 0", e);
    end
    e = frame_errs(82, q[1], 3);
    vectors++;
    if (e !== 0) begin
      errors++;
      $display("FAIL per_frame1: bad %0d want 0", e);
    end
    vectors++;
    if (done_q[82] !== 1'b1 || done_q[112] !== 1'b1) begin
      errors++;
      $display("FAIL per_done: got %b%b want 11",
               done_q[82], done_q[112]);
    end
    vectors++;
    if (active_count(0) !== 110) begin
      errors++;
      $display("FAIL per_len: got %0d want 110", active_count(0));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    int n;
    do_reset();
    bus.CLKS_PER_BIT = 16'd10;
    q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    write_bytes(q);
    run(27);
    vectors++;
    if (cnt_q[30] !== 2 || act_q[30] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: count %0d act %b want 2 1",
               cnt_q[30], act_q[30]);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    vectors++;
    if (ser_q[31] !== 1'b1 || act_q[31] !== 1'b0) begin
      errors++;
      $display("FAIL rmid_line: ser %b act %b want 1 0",
               ser_q[31], act_q[31]);
    end
    vectors++;
    if (cnt_q[31] !== 0 || rdy_q[31] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_fifo: count %0d rdy %b want 0 1",
               cnt_q[31], rdy_q[31]);
    end
    run(150);
    n = active_count(31) + done_count(31);
    vectors++;
    if (n !== 0) begin
      errors++;
      $display("FAIL rmid_quiet: act+done %0d want 0", n);
    end
  endtask

  task automatic test_zero_period();
    logic [7:0] q[$];
    int e;
    do_reset();
    bus.CLKS_PER_BIT = 16'd0;
    q = '{8'h81};
    write_bytes(q);
    run(20);
    e = frame_errs(2, 8'h81, 1);
    vectors++;
    if (e !== 0) begin
      errors++;
      $display("FAIL zero_frame: bad %0d want 0", e);
    end
    vectors++;
    if (done_q[12] !== 1'b1 || act_q[12] !== 1'b0) begin
      errors++;
      $display("FAIL zero_end: done %b act %b want 1 0",
               done_q[12], act_q[12]);
    end
    vectors++;
    if (active_count(0) !== 10) begin
      errors++;
      $display("FAIL zero_len: got %0d want 10", active_count(0));
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int p;
    int pe;
    int n;
    int e;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      p  = $urandom_range(0, 6);
      pe = (p == 0) ? 1 : p;
      n  = $urandom_range(1, 4);
      bus.CLKS_PER_BIT = 16'(p);
      q.delete();
      for (int i = 0; i < n; i++)
        q.push_back(8'($urandom));
      write_bytes(q);
      run(10*pe*n + 10);
      for (int f = 0; f < n; f++) begin
        e = frame_errs(2 + 10*pe*f, q[f], pe);
        vectors++;
        if (e !== 0) begin
          errors++;
          $display("FAIL rand%0d_frame%0d: bad %0d want 0",
                   r, f, e);
        end
      end
      vectors++;
      if (done_count(0) !== n ||
          active_count(0) !== 10*pe*n) begin
        errors++;
        $display("FAIL rand%0d_totals: done %0d act %0d want %0d %0d",
                 r, done_count(0), active_count(0), n, 10*pe*n);
      end
    end
  endtask

  initial begin
    bus.i_Tx_DV      = 1'b0;
    bus.i_Tx_Byte    = 8'h00;
    bus.CLKS_PER_BIT = 16'd4;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_period_change();
    test_reset_mid();
    test_zero_period();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
